// File: rtl/neighbor_table_update_if.sv
// neighbor_table_update_if: shared data-memory port of the neighbor table writer.
// The master drives a registered word address, write data and write enable;
// read data returns in the cycle after the address changes.
interface neighbor_table_update_if;
   logic [10:0] address;
   logic [15:0] data_out;
   logic        wr_en;
   logic [15:0] data_in;

   modport master (
      output address,
      output data_out,
      output wr_en,
      input  data_in
   );

   modport slave (
      input  address,
      input  data_out,
      input  wr_en,
      output data_in
   );
endinterface

// File: rtl/neighbor_table_update.sv
// neighbor_table_update: inserts or refreshes one advertised neighbor (ID, hops,
// Q value) in the neighbor table held in shared data memory.
// Table words: IDs at 0x072+2n, hops at 0x132+2n, Q at 0x172+2n, count at 0x2C4.
// The count word is written last, so an interrupted append never becomes visible.
// Optional feature macro: NTU_MIN_HOPS_EN -- a refresh only overwrites the stored
// hop count when the advertised one is strictly smaller.
module neighbor_table_update #(
   parameter int MAX_NEIGHBORS = 32
) (
   input  logic                    clock,
   input  logic                    nrst,
   input  logic                    en,
   input  logic                    start,
   input  logic [15:0]             nodeID,
   input  logic [15:0]             pkt_nodeID,
   input  logic [15:0]             pkt_hops,
   input  logic [15:0]             pkt_QValue,
   neighbor_table_update_if.master mbus,
   output logic                    done,
   output logic                    new_entry,
   output logic                    table_full
);
   localparam int CW = $clog2(MAX_NEIGHBORS + 1);
   localparam logic [10:0]   ID_BASE    = 11'h072;
   localparam logic [10:0]   HOPS_BASE  = 11'h132;
   localparam logic [10:0]   Q_BASE     = 11'h172;
   localparam logic [10:0]   COUNT_ADDR = 11'h2C4;
   localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_NEIGHBORS);

   typedef enum logic [3:0] {
      S_WAIT    = 4'd0,
      S_START   = 4'd1,
      S_COUNT   = 4'd2,
      S_SCAN    = 4'd3,
      S_APPEND  = 4'd4,
      S_WRID    = 4'd5,
      S_WRHOPS  = 4'd6,
      S_WRQ     = 4'd7,
      S_WRCOUNT = 4'd8,
      S_DONE    = 4'd9,
      S_RDHOPS  = 4'd10
   } state_t;

   state_t        state_q;
   logic [CW-1:0] n_q;
   logic [CW-1:0] count_q;
   logic [15:0]   id_q;
   logic [15:0]   hops_q;
   logic [15:0]   qval_q;
   logic          append_q;
   logic [10:0]   address_q;
   logic [15:0]   data_out_q;
   logic          wr_en_q;
   logic          done_q;
   logic          new_entry_q;
   logic          table_full_q;

   logic [CW-1:0] count_d;
   logic [CW-1:0] n_inc_d;
   logic [15:0]   count_inc_d;

   // Word address of slot idx in the region starting at base (2-byte spacing).
   function automatic logic [10:0] slot_addr(input logic [10:0] base, input logic [CW-1:0] idx);
      return base + {{(10-CW){1'b0}}, idx, 1'b0};
   endfunction

   // A stored count beyond capacity is clamped so the scan never leaves the table.
   assign count_d     = (mbus.data_in > 16'(MAX_NEIGHBORS)) ? MAX_CNT : mbus.data_in[CW-1:0];
   assign n_inc_d     = n_q + {{(CW-1){1'b0}}, 1'b1};
   assign count_inc_d = {{(16-CW){1'b0}}, count_q} + 16'd1;

   assign mbus.address  = address_q;
   assign mbus.data_out = data_out_q;
   assign mbus.wr_en    = wr_en_q;
   assign done          = done_q;
   assign new_entry     = new_entry_q;
   assign table_full    = table_full_q;

   // Control FSM: scan for the ID, then refresh or append, all outputs registered.
   always_ff @(posedge clock) begin
      if (nrst) begin
         state_q      <= S_WAIT;
         n_q          <= {CW{1'b0}};
         count_q      <= {CW{1'b0}};
         id_q         <= 16'd0;
         hops_q       <= 16'd0;
         qval_q       <= 16'd0;
         append_q     <= 1'b0;
         address_q    <= 11'd0;
         data_out_q   <= 16'd0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
         new_entry_q  <= 1'b0;
         table_full_q <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         new_entry_q  <= 1'b0;
         table_full_q <= 1'b0;
         case (state_q)
            S_WAIT: begin
               wr_en_q <= 1'b0;
               if (en) begin
                  n_q      <= {CW{1'b0}};
                  count_q  <= {CW{1'b0}};
                  append_q <= 1'b0;
                  state_q  <= S_START;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_START: begin
               wr_en_q <= 1'b0;
               if (start) begin
                  id_q     <= pkt_nodeID;
                  hops_q   <= pkt_hops;
                  qval_q   <= pkt_QValue;
                  append_q <= 1'b0;
                  if (pkt_nodeID == nodeID) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     address_q <= COUNT_ADDR;
                     state_q   <= S_COUNT;
                  end
               end else begin
                  state_q <= S_START;
               end
            end
            S_COUNT: begin
               count_q <= count_d;
               if (count_d == {CW{1'b0}}) begin
                  state_q <= S_APPEND;
               end else begin
                  n_q       <= {CW{1'b0}};
                  address_q <= ID_BASE;
                  state_q   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (mbus.data_in == id_q) begin
                  address_q <= slot_addr(HOPS_BASE, n_q);
`ifdef NTU_MIN_HOPS_EN
                  state_q   <= S_RDHOPS;
`else
                  data_out_q <= hops_q;
                  wr_en_q    <= 1'b1;
                  state_q    <= S_WRHOPS;
`endif
               end else begin
                  n_q <= n_inc_d;
                  if (n_inc_d == count_q) begin
                     state_q <= S_APPEND;
                  end else begin
                     address_q <= slot_addr(ID_BASE, n_inc_d);
                     state_q   <= S_SCAN;
                  end
               end
            end
`ifdef NTU_MIN_HOPS_EN
            S_RDHOPS: begin
               wr_en_q <= 1'b1;
               if (hops_q < mbus.data_in) begin
                  data_out_q <= hops_q;
                  state_q    <= S_WRHOPS;
               end else begin
                  address_q  <= slot_addr(Q_BASE, n_q);
                  data_out_q <= qval_q;
                  state_q    <= S_WRQ;
               end
            end
`endif
            S_APPEND: begin
               if (count_q == MAX_CNT) begin
                  table_full_q <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  n_q        <= count_q;
                  address_q  <= slot_addr(ID_BASE, count_q);
                  data_out_q <= id_q;
                  wr_en_q    <= 1'b1;
                  append_q   <= 1'b1;
                  state_q    <= S_WRID;
               end
            end
            S_WRID: begin
               address_q  <= slot_addr(HOPS_BASE, n_q);
               data_out_q <= hops_q;
               wr_en_q    <= 1'b1;
               state_q    <= S_WRHOPS;
            end
            S_WRHOPS: begin
               address_q  <= slot_addr(Q_BASE, n_q);
               data_out_q <= qval_q;
               wr_en_q    <= 1'b1;
               state_q    <= S_WRQ;
            end
            S_WRQ: begin
               if (append_q) begin
                  address_q  <= COUNT_ADDR;
                  data_out_q <= count_inc_d;
                  wr_en_q    <= 1'b1;
                  state_q    <= S_WRCOUNT;
               end else begin
                  wr_en_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_WRCOUNT: begin
               wr_en_q     <= 1'b0;
               done_q      <= 1'b1;
               new_entry_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               wr_en_q <= 1'b0;
               if (en) begin
                  state_q <= S_START;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            default: begin
               wr_en_q <= 1'b0;
               state_q <= S_WAIT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neighbor_table_update.sv
// tb_neighbor_table_update: directed and randomized packets against a timing-level
// model of the neighbor table writer, with a word-addressed memory in the bench.
module tb_neighbor_table_update;
   logic        clock;
   logic        nrst;
   logic        en;
   logic        start;
   logic [15:0] node_id;
   logic [15:0] pkt_id;
   logic [15:0] pkt_hops;
   logic [15:0] pkt_q;
   logic        done;
   logic        new_entry;
   logic        table_full;

   logic [15:0] ram [0:1023];
   int total;
   int bad;

   // expected schedule for the packet in flight
   int          e_n;
   int          e_cyc [4];
   logic [10:0] e_adr [4];
   logic [15:0] e_dat [4];
   int          e_done;
   bit          e_ne;
   bit          e_tf;

   neighbor_table_update_if bus ();

   assign bus.data_in = ram[bus.address[10:1]];

   neighbor_table_update #(.MAX_NEIGHBORS(32)) dut (
      .clock      (clock),
      .nrst       (nrst),
      .en         (en),
      .start      (start),
      .nodeID     (node_id),
      .pkt_nodeID (pkt_id),
      .pkt_hops   (pkt_hops),
      .pkt_QValue (pkt_q),
      .mbus       (bus),
      .done       (done),
      .new_entry  (new_entry),
      .table_full (table_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic add_wr(input int cyc, input int adr, input int dat);
      e_cyc[e_n] = cyc;
      e_adr[e_n] = 11'(adr);
      e_dat[e_n] = 16'(dat);
      e_n++;
   endtask

   // Predict writes, done cycle and flags from the table contents and the packet.
   task automatic predict(input logic [15:0] pid, input logic [15:0] ph, input logic [15:0] pq);
      int c;
      int k;
      e_n = 0; e_ne = 1'b0; e_tf = 1'b0;
      if (pid == node_id) begin
         e_done = 1;
      end else begin
         c = (ram['h2C4/2] > 16'd32) ? 32 : int'(ram['h2C4/2]);
         k = -1;
         for (int i = 0; i < c; i++)
            if (k < 0 && ram['h072/2 + i] == pid) k = i;
         if (k >= 0) begin
`ifdef NTU_MIN_HOPS_EN
            if (ph < ram['h132/2 + k]) begin
               add_wr(4 + k, 'h132 + 2*k, ph);
               add_wr(5 + k, 'h172 + 2*k, pq);
               e_done = 6 + k;
            end else begin
               add_wr(4 + k, 'h172 + 2*k, pq);
               e_done = 5 + k;
            end
`else
            add_wr(3 + k, 'h132 + 2*k, ph);
            add_wr(4 + k, 'h172 + 2*k, pq);
            e_done = 5 + k;
`endif
         end else if (c == 32) begin
            e_tf = 1'b1;
            e_done = c + 3;
         end else begin
            add_wr(c + 3, 'h072 + 2*c, pid);
            add_wr(c + 4, 'h132 + 2*c, ph);
            add_wr(c + 5, 'h172 + 2*c, pq);
            add_wr(c + 6, 'h2C4, c + 1);
            e_done = c + 7;
            e_ne = 1'b1;
         end
      end
   endtask

   // Apply a DUT write seen in the current cycle once the clock edge has passed.
   task automatic mem_cycle();
      logic        pend;
      logic [10:0] pa;
      logic [15:0] pd;
      pend = bus.wr_en; pa = bus.address; pd = bus.data_out;
      @(posedge clock);
      #1;
      if (pend) ram[pa[10:1]] = pd;
   endtask

   // Issue one packet and compare outputs against the model every cycle until done.
   task automatic run_packet(input logic [15:0] pid, input logic [15:0] ph, input logic [15:0] pq,
                             output int done_at);
      int  cyc;
      bit  exp_wr;
      logic [10:0] ea;
      logic [15:0] ed;
      predict(pid, ph, pq);
      @(negedge clock);
      start = 1'b1; pkt_id = pid; pkt_hops = ph; pkt_q = pq;
      @(posedge clock);
      #1;
      start = 1'b0;
      cyc = 0;
      done_at = -1;
      for (int t = 0; t < 60 && done_at < 0; t++) begin
         @(negedge clock);
         exp_wr = 1'b0; ea = 11'd0; ed = 16'd0;
         for (int j = 0; j < e_n; j++)
            if (e_cyc[j] == cyc + 1) begin exp_wr = 1'b1; ea = e_adr[j]; ed = e_dat[j]; end
         chk("wr_en", {31'd0, bus.wr_en}, {31'd0, exp_wr});
         if (exp_wr) begin
            chk("address", {21'd0, bus.address}, {21'd0, ea});
            chk("data_out", {16'd0, bus.data_out}, {16'd0, ed});
         end
         chk("done", {31'd0, done}, {31'd0, (cyc + 1 == e_done)});
         if (done) begin
            done_at = cyc + 1;
            chk("new_entry", {31'd0, new_entry}, {31'd0, e_ne});
            chk("table_full", {31'd0, table_full}, {31'd0, e_tf});
         end
         mem_cycle();
         cyc++;
      end
      if (done_at < 0) begin
         total++; bad++;
         $display("FAIL done_timeout actual=none required=cycle %0d", e_done);
      end
   endtask

   task automatic load_table(input int stored, input int base_id);
      for (int i = 0; i < 32; i++) begin
         ram['h072/2 + i] = 16'(base_id + i);
         ram['h132/2 + i] = 16'($urandom_range(1, 15));
         ram['h172/2 + i] = 16'($urandom);
      end
      ram['h2C4/2] = 16'(stored);
   endtask

   initial begin
      int d;
      int c;
      int sel;
      logic [15:0] pid;
      total = 0; bad = 0;
      nrst = 1'b1; en = 1'b0; start = 1'b0; node_id = 16'h0003;
      pkt_id = 16'd0; pkt_hops = 16'd0; pkt_q = 16'd0;
      for (int i = 0; i < 1024; i++) ram[i] = 16'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_new_entry", {31'd0, new_entry}, 32'd0);
      chk("rst_table_full", {31'd0, table_full}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("rst_address", {21'd0, bus.address}, 32'd0);
      chk("rst_data_out", {16'd0, bus.data_out}, 32'd0);
      nrst = 1'b0; en = 1'b1;
      repeat (3) @(negedge clock);

      // empty table append
      load_table(0, 16'h0100);
      run_packet(16'h0005, 16'd2, 16'h0100, d);
      chk("empty_done_cycle", d, 32'd7);
      chk("empty_id", {16'd0, ram['h072/2]}, 32'h0005);
      chk("empty_hops", {16'd0, ram['h132/2]}, 32'h0002);
      chk("empty_q", {16'd0, ram['h172/2]}, 32'h0100);
      chk("empty_count", {16'd0, ram['h2C4/2]}, 32'h0001);

      // refresh of entry 1 in a table of 3
      load_table(3, 16'h0200);
      ram['h074/2] = 16'h0009;
      run_packet(16'h0009, 16'd4, 16'h0200, d);
      chk("refresh_done_cycle", d, 32'd6);
      chk("refresh_hops", {16'd0, ram['h134/2]}, 32'h0004);
      chk("refresh_q", {16'd0, ram['h174/2]}, 32'h0200);
      chk("refresh_count", {16'd0, ram['h2C4/2]}, 32'h0003);

      // full table drops a new ID
      load_table(32, 16'h0100);
      run_packet(16'h0040, 16'd1, 16'h0011, d);
      chk("full_done_cycle", d, 32'd35);
      chk("full_count", {16'd0, ram['h2C4/2]}, 32'h0020);

      // own echo
      run_packet(16'h0003, 16'd1, 16'h0011, d);
      chk("own_done_cycle", d, 32'd1);

      // refresh of entry 0 with worse hops
      load_table(1, 16'h0300);
      ram['h072/2] = 16'h0021;
      ram['h132/2] = 16'h0001;
      run_packet(16'h0021, 16'd3, 16'h0033, d);
      chk("minhops_done_cycle", d, 32'd5);
`ifdef NTU_MIN_HOPS_EN
      chk("minhops_hops", {16'd0, ram['h132/2]}, 32'h0001);
`else
      chk("minhops_hops", {16'd0, ram['h132/2]}, 32'h0003);
`endif
      chk("minhops_q", {16'd0, ram['h172/2]}, 32'h0033);

      // reset while the hops word of an append is being written
      load_table(0, 16'h0400);
      @(negedge clock);
      start = 1'b1; pkt_id = 16'h0077; pkt_hops = 16'd5; pkt_q = 16'h0055;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         mem_cycle();
      end
      @(negedge clock);
      chk("abort_hops_pending", {31'd0, bus.wr_en}, 32'd1);
      nrst = 1'b1;
      mem_cycle();
      @(negedge clock);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("abort_address", {21'd0, bus.address}, 32'd0);
      chk("abort_data_out", {16'd0, bus.data_out}, 32'd0);
      chk("abort_count", {16'd0, ram['h2C4/2]}, 32'h0000);
      nrst = 1'b0;
      repeat (3) @(negedge clock);

      // randomized packets, table sometimes carried over from the previous packet
      for (int it = 0; it < 25; it++) begin
         if (it == 0 || $urandom_range(0, 2) == 0) begin
            c = $urandom_range(0, 33);
            load_table((c == 33) ? 40 + $urandom_range(0, 100) : c, $urandom_range(16, 16'h7000));
         end
         c = (ram['h2C4/2] > 16'd32) ? 32 : int'(ram['h2C4/2]);
         sel = $urandom_range(0, 5);
         if (sel == 0) pid = node_id;
         else if (sel <= 3 && c > 0) pid = ram['h072/2 + $urandom_range(0, c - 1)];
         else pid = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
         run_packet(pid, 16'($urandom_range(0, 15)), 16'($urandom), d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/neighbor_table_update.md
# neighbor_table_update

- Writer side of the node's neighbor table: takes one received neighbor advertisement (ID, hop count, Q value) per `start` and inserts or refreshes that neighbor in the table in shared data memory.
- Table layout, all 16-bit words stored at 2-byte spacing:
  - neighborID at 0x072+2n
  - neighborHops at 0x132+2n
  - neighborQValue at 0x172+2n
  - neighborCount at 0x2C4
- The best-neighbor selection block reads this table afterwards.
- Sits between the packet receive path and the shared memory arbiter.

## Interface
Parameters:
- `MAX_NEIGHBORS`, 32: table capacity in entries. It fits the 64-byte ID, hops and Q regions.

Ports:
- `clock` in 1: single clock, rising edge.
- `nrst` in 1: reset, synchronous, active-high.
- `en` in 1: block enable. Sampled only in `s_wait` and `s_done`.
- `start` in 1: level, sampled in `s_start`. The `pkt_*` fields are latched on that same edge.
- `nodeID` in 16: this node's own ID.
- `pkt_nodeID`, `pkt_hops`, `pkt_QValue` in 16 each: advertised neighbor fields.
- `data_in` in 16: memory read data. It is valid in the cycle after `address` changes.
- `address` out 11: registered memory address.
- `data_out` out 16: registered write data.
- `wr_en` out 1: registered. Memory writes `data_out` to `address` on the edge that ends a cycle with `wr_en`=1.
- `done` out 1: one-cycle pulse, packet handled.
- `new_entry` out 1: valid with `done`. 1 = entry appended.
- `table_full` out 1: valid with `done`. 1 = packet dropped because the table is full.

## Operation
- All outputs reset to 0. `n`, `count` and the latched packet registers also reset to 0. State resets to `s_wait`.
- A reset mid-operation aborts at the next edge. A partially written entry is not rolled back, but `neighborCount` is written last, so a half-appended entry stays invisible.
- States:
  - `s_wait`: if `en`, clear internals and go to `s_start`.
  - `s_start`: on `start`, latch the packet.
    - If `pkt_nodeID==nodeID` (own echo), go to `s_done` with `new_entry`=0, `table_full`=0.
    - Otherwise set `address`=0x2C4 and go to `s_count`.
  - `s_count`: `count`=min(`data_in`, `MAX_NEIGHBORS`).
    - If `count`==0, go to `s_append`.
    - Otherwise set `n`=0, `address`=0x072, go to `s_scan`.
  - `s_scan`: one entry per cycle.
    - If `data_in==pkt_nodeID`: match, refresh entry `n`, go to `s_wrHops` (or `s_rdHops`, see Configuration).
    - Else `n`=n+1. If `n`==`count`, go to `s_append`; otherwise set `address`=0x072+2n and stay.
  - `s_append`:
    - If `count`==`MAX_NEIGHBORS`: `table_full`=1, go to `s_done`, no writes.
    - Else `n`=`count`; write ID (`address` 0x072+2n, `data_out`=`pkt_nodeID`); go to `s_wrID`.
  - `s_wrID`: write hops at 0x132+2n; go to `s_wrHops`.
  - `s_wrHops`: write Q at 0x172+2n; go to `s_wrQ`.
  - `s_wrQ`:
    - If appending, write `count`+1 at 0x2C4 and go to `s_wrCount`.
    - Else `wr_en`=0 and go to `s_done`.
  - `s_wrCount`: `wr_en`=0; go to `s_done`.
  - `s_done`: `done`=1 for this cycle only. If `en`, go to `s_start`; else go to `s_wait`.
- On a match (refresh) path, `s_scan` issues the hops write at 0x132+2n directly.
- Address arithmetic: `address` = base + 2·n, computed in 11 bits. n ≤ 31, so there is no wrap.
- A stored count greater than `MAX_NEIGHBORS` is clamped for the scan. The next append writes the clamped value +1 only if space remains.
- Duplicate IDs are never created. The first match wins.
- `start` held high is seen again only after `done`, on re-entry to `s_start`.

## Timing
- Cycle 0 is the edge that samples `start` in `s_start`.
- Refresh, match at entry k:
  - hops write visible cycle 3+k
  - Q write visible cycle 4+k
  - `done` at cycle 5+k
- Append with c existing entries (c < `MAX_NEIGHBORS`):
  - ID write visible c+3
  - hops c+4
  - Q c+5
  - count c+6
  - `done` c+7
- Full table (c=32): `done` with `table_full` at cycle 35.
- Own-ID packet: `done` at cycle 1.
- Throughput: one packet in flight. `start` is ignored outside `s_start`.

## Configuration
- `NTU_MIN_HOPS_EN` defined:
  - A match goes to `s_rdHops`, which reads stored hops at 0x132+2k.
  - If `pkt_hops` < stored: hops write visible at 4+k, Q write at 5+k, `done` at 6+k.
  - Otherwise the hops write is skipped: Q write at 4+k, `done` at 5+k.
- `NTU_MIN_HOPS_EN` undefined: a match always overwrites hops. Refresh timing is as in Timing.

## Test plan
- Empty table (count 0), packet ID 0x0005, hops 2, Q 0x0100 -> writes [0x072]=5, [0x132]=2, [0x172]=0x0100, [0x2C4]=1; `done` at cycle 7 with `new_entry`=1.
- Table of 3 with entry 1 ID 0x0009; packet ID 9, hops 4, Q 0x0200 -> writes [0x134]=4, [0x174]=0x0200; count stays 3; `done` at cycle 6 with `new_entry`=0.
- Table holding 32 distinct IDs, new ID 0x0040 -> no writes; `done` at cycle 35 with `table_full`=1.
- `pkt_nodeID`==`nodeID`=0x0003 -> no memory access; `done` at cycle 1.
- With `NTU_MIN_HOPS_EN`, entry 0 stores hops 1; packet with hops 3 -> only the Q write happens; `done` at cycle 5.
- `nrst` asserted during `s_wrHops` of an append -> outputs 0 next cycle, [0x2C4] unchanged.
